// File: rtl/jk_seq_ctrl_311.sv
// Sequencing controller for a bank of JK flip-flops: accepts one command, drives
// per-bit J/K vectors for the required number of edges, then pulses done.
module jk_seq_ctrl_311 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_311,
  input  logic             reset,
  input  logic             start_311,
  input  logic [2:0]       op_311,
  input  logic [WIDTH-1:0] data_311,
  input  logic [CNT_W-1:0] steps_311,
  output logic             busy_311,
  output logic             done_311,
  output logic [WIDTH-1:0] j_311,
  output logic [WIDTH-1:0] k_311,
  output logic [WIDTH-1:0] q_311,
  output logic [WIDTH-1:0] qb_311
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_SET    = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_UP     = 3'b101;
  localparam logic [2:0] OP_DOWN   = 3'b110;
  localparam logic [2:0] OP_SHIFT  = 3'b111;

  state_t           state, state_nxt;
  logic [2:0]       op_l;
  logic [WIDTH-1:0] data_l;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             zero_multi;

  // Bit i toggles when every lower bit matches the carry/borrow condition.
  function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = acc;
      acc  = acc & v[i];
    end
    return r;
  endfunction

  assign accept     = (state == IDLE) && start_311;
  assign zero_multi = op_311[2] && (steps_311 == '0);

  always_ff @(posedge clk_311) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_311) state_nxt = zero_multi ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_311 = (state == RUN);
    done_311 = (state == DONE);
    j_311    = '0;
    k_311    = '0;
    if (state == RUN) begin
      unique case (op_l)
        OP_HOLD:   begin j_311 = '0;  k_311 = '0;      end
        OP_LOAD:   begin j_311 = data_l; k_311 = ~data_l; end
        OP_CLEAR:  begin j_311 = '0;  k_311 = '1;      end
        OP_SET:    begin j_311 = '1;  k_311 = '0;      end
        OP_TOGGLE: begin j_311 = '1;  k_311 = '1;      end
        OP_UP:     begin j_311 = prefix_and(q);  k_311 = prefix_and(q);  end
        OP_DOWN:   begin j_311 = prefix_and(~q); k_311 = prefix_and(~q); end
        OP_SHIFT:  begin
          j_311 = {q[WIDTH-2:0], data_l[0]};
          k_311 = {~q[WIDTH-2:0], ~data_l[0]};
        end
        default:   begin j_311 = '0;  k_311 = '0;      end
      endcase
    end
  end

  // Single-step ops run for exactly one edge regardless of steps_311.
  always_ff @(posedge clk_311) begin
    if (reset) begin
      op_l   <= '0;
      data_l <= '0;
      cnt    <= '0;
      q      <= '0;
    end else if (accept) begin
      op_l   <= op_311;
      data_l <= data_311;
      cnt    <= op_311[2] ? steps_311 : CNT_W'(1);
    end else if (state == RUN) begin
      q   <= (j_311 & ~q) | (~k_311 & q);
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign q_311  = q;
  assign qb_311 = ~q;

endmodule

// File: tb/tb_jk_seq_ctrl_311.sv
// Randomized scoreboard bench for jk_seq_ctrl_311: a behavioural model queues
// every expected bank value and completion; a negedge monitor consumes them.
module tb_jk_seq_ctrl_311;

  logic       clk_311 = 1'b0;
  logic       reset;
  logic       start_311;
  logic [2:0] op_311;
  logic [3:0] data_311;
  logic [7:0] steps_311;
  logic       busy_311, done_311;
  logic [3:0] j_311, k_311, q_311, qb_311;

  typedef struct {
    logic [3:0] q;
    int         n;
  } cmd_t;

  logic [3:0] step_q[$];
  cmd_t       cmd_q[$];
  logic [3:0] q_model;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic       prev_busy = 1'b0;

  jk_seq_ctrl_311 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk_311(clk_311), .reset(reset), .start_311(start_311), .op_311(op_311),
    .data_311(data_311), .steps_311(steps_311), .busy_311(busy_311),
    .done_311(done_311), .j_311(j_311), .k_311(k_311), .q_311(q_311),
    .qb_311(qb_311)
  );

  always #5 clk_311 = ~clk_311;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Bank value after one edge of the given operation, in plain arithmetic.
  function automatic logic [3:0] model_step(logic [2:0] o, logic [3:0] cur, logic [3:0] d);
    case (o)
      3'd0:    return cur;
      3'd1:    return d;
      3'd2:    return 4'h0;
      3'd3:    return 4'hF;
      3'd4:    return ~cur;
      3'd5:    return cur + 4'd1;
      3'd6:    return cur - 4'd1;
      default: return {cur[2:0], d[0]};
    endcase
  endfunction

  always @(negedge clk_311) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (prev_busy) begin
        if (step_q.size() == 0) check("unexpected_update_q", {28'd0, q_311}, 32'hFFFF_FFFF);
        else check("step_q", {28'd0, q_311}, {28'd0, step_q.pop_front()});
      end
      if (busy_311) busy_cnt++;
      else check("idle_jk", {24'd0, j_311, k_311}, 32'd0);
      if (done_311) begin
        done_cnt++;
        if (cmd_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cmd_t c;
          c = cmd_q.pop_front();
          check("done_q", {28'd0, q_311}, {28'd0, c.q});
          check("done_qb", {28'd0, qb_311}, {28'd0, ~c.q});
          check("busy_cycles", busy_cnt, c.n);
          check("done_busy_excl", {31'd0, busy_311}, 32'd0);
        end
        busy_cnt = 0;
      end
      prev_busy = busy_311;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [3:0] d, input logic [7:0] s,
                       input logic noisy);
    int   n;
    cmd_t c;
    n = o[2] ? int'(s) : 1;
    for (int i = 0; i < n; i++) begin
      q_model = model_step(o, q_model, d);
      step_q.push_back(q_model);
    end
    c.q = q_model;
    c.n = n;
    cmd_q.push_back(c);
    start_311 = 1'b1; op_311 = o; data_311 = d; steps_311 = s;
    @(posedge clk_311); #1;
    start_311 = noisy;
    op_311    = 3'($urandom);
    data_311  = 4'($urandom);
    steps_311 = 8'($urandom);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (cmd_q.size() != 0 && cyc < 400) begin
      @(posedge clk_311);
      cyc++;
    end
    if (cmd_q.size() != 0) begin
      check("done_timeout", cmd_q.size(), 0);
      cmd_q.delete();
      step_q.delete();
    end
    #1;
    start_311 = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [3:0] d, input logic [7:0] s,
                     input logic noisy);
    issue(o, d, s, noisy);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    reset = 1'b1; start_311 = 1'b0; op_311 = '0; data_311 = '0; steps_311 = '0;
    q_model = 4'h0;
    repeat (2) @(posedge clk_311);
    #1 reset = 1'b0;
    @(negedge clk_311);
    check("reset_q", {28'd0, q_311}, 32'h0);
    check("reset_qb", {28'd0, qb_311}, 32'hF);
    check("reset_busy_done", {30'd0, busy_311, done_311}, 32'd0);
    check("reset_jk", {24'd0, j_311, k_311}, 32'd0);
    @(posedge clk_311); #1;

    run(3'b001, 4'b1010, 8'd0, 1'b0);
    run(3'b001, 4'b1110, 8'd9, 1'b0);
    run(3'b101, 4'b0000, 8'd3, 1'b0);
    run(3'b001, 4'b0001, 8'd0, 1'b0);
    run(3'b110, 4'b0000, 8'd2, 1'b0);
    run(3'b100, 4'b0000, 8'd1, 1'b0);
    run(3'b010, 4'b1111, 8'd7, 1'b0);
    run(3'b111, 4'b0001, 8'd4, 1'b0);
    run(3'b101, 4'b0000, 8'd0, 1'b0);
    run(3'b101, 4'b0000, 8'd5, 1'b1);
    run(3'b000, 4'b1111, 8'd3, 1'b1);
    run(3'b011, 4'b0000, 8'd0, 1'b0);
    run(3'b110, 4'b0000, 8'd255, 1'b0);
    check("after_255_down", {28'd0, q_311}, {28'd0, q_model});

    for (int i = 0; i < 30; i++)
      run(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom_range(0, 12)),
          1'($urandom_range(0, 1)));

    // Abort a 10-step count on its 4th RUN edge.
    done_before = done_cnt;
    issue(3'b101, 4'b0000, 8'd10, 1'b0);
    repeat (3) @(posedge clk_311);
    #1 reset = 1'b1;
    @(posedge clk_311);
    #1 reset = 1'b0;
    step_q.delete();
    cmd_q.delete();
    q_model = 4'h0;
    repeat (4) @(negedge clk_311);
    check("abort_q", {28'd0, q_311}, 32'h0);
    check("abort_busy", {31'd0, busy_311}, 32'd0);
    check("abort_no_done", done_cnt, done_before);
    @(posedge clk_311); #1;
    run(3'b011, 4'b0000, 8'd0, 1'b0);
    check("set_after_abort", {28'd0, q_311}, 32'hF);

    repeat (3) @(posedge clk_311);
    check("queues_drained", step_q.size() + cmd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_seq_ctrl_311.md
Name: jk_seq_ctrl_311

Overview:
- Sequencing controller for a WIDTH-bit bank of JK flip-flops. The bank is held internally as a JK register with next state q = (J & ~q) | (~K & q).
- Accepts a one-cycle command (op + step count), then drives per-bit J/K vectors for the required number of clock edges.
- Implements load, clear, set, toggle, up/down count and shift-in on the JK bank.
- Signals completion with busy/done. Sits between the control logic and the flip-flop datapath.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the step counter and steps_311 port.

Ports:
- clk_311  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_311  in  1  command strobe; sampled only in IDLE.
- op_311  in  3  operation code, latched with start_311.
- data_311  in  WIDTH  load value (LOAD) or serial-in bit data_311[0] (SHIFT); latched with start_311.
- steps_311  in  CNT_W  number of edges for multi-step ops; latched with start_311.
- busy_311  out  1  high while in RUN.
- done_311  out  1  one-cycle completion pulse.
- j_311  out  WIDTH  J vector applied to the bank this cycle.
- k_311  out  WIDTH  K vector applied to the bank this cycle.
- q_311  out  WIDTH  bank state.
- qb_311  out  WIDTH  always ~q_311.

Behaviour:
- Reset (synchronous, active-high; reset = 1 at a rising edge): state IDLE, q_311 = 0, qb_311 = all ones, busy_311 = 0, done_311 = 0, latched op/data/steps = 0, step counter = 0.
- Reset mid-RUN aborts the command: no done_311 pulse, and q_311 is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start_311 = 1; op, data and steps are latched at that edge.
- IDLE -> DONE instead, for a multi-step op with steps_311 = 0. q_311 is unchanged.
- RUN -> DONE on the edge that applies the final step.
- DONE -> IDLE unconditionally after 1 cycle.
- start_311 is ignored in RUN and DONE. No queuing.
- Outputs per state:
  - busy_311 = 1 only in RUN.
  - done_311 = 1 only in DONE.
  - j_311 = k_311 = 0 in IDLE and DONE, so the bank holds.
- Single-step ops ignore steps_311 and apply exactly 1 edge:
  - 000 HOLD: J = 0, K = 0.
  - 001 LOAD: J = data, K = ~data.
  - 010 CLEAR: J = 0, K = all ones.
  - 011 SET: J = all ones, K = 0.
- Multi-step ops apply steps_311 edges. J/K are recomputed combinationally each RUN cycle from the current q_311:
  - 100 TOGGLE: J = K = all ones.
  - 101 COUNT_UP: J[i] = K[i] = AND of q[i-1:0], with bit 0 = 1. Wraps from all ones to 0.
  - 110 COUNT_DOWN: J[i] = K[i] = AND of qb[i-1:0], with bit 0 = 1. Wraps from 0 to all ones.
  - 111 SHIFT: J[0] = data[0], K[0] = ~data[0]; for i > 0, J[i] = q[i-1], K[i] = qb[i-1].
- Latency:
  - start sampled at edge t.
  - First bank update at edge t+1.
  - Last bank update at edge t+N (N = 1 for single-step ops).
  - done_311 is high during the cycle after edge t+N.
  - busy_311 is high for exactly N cycles.
- Step counter:
  - Loaded with N at accept; decremented each RUN edge; RUN exits when the counter reaches 0.
  - N = 2^CNT_W - 1 (255) is fully supported with no overflow.
- Inputs changing during RUN have no effect; only latched copies are used.

Test Plan:
- Reset then LOAD: reset for 1 edge, then start with op = 001, data = 4'b1010 -> q_311 = 1010 and qb_311 = 0101 one edge after accept; busy_311 high 1 cycle; done_311 pulses once.
- COUNT_UP with wrap: q = 1110, op = 101, steps = 3 -> q sequence 1111, 0000, 0001; busy_311 high 3 cycles; done_311 pulses after the third update.
- COUNT_DOWN and TOGGLE:
  - q = 0001, op = 110, steps = 2 -> q = 0000, then 1111.
  - Then op = 100, steps = 1 -> q = 0000.
- SHIFT: q = 0000, op = 111, data[0] = 1, steps = 4 -> q = 0001, 0011, 0111, 1111.
- Zero steps and ignored start:
  - op = 101, steps = 0 -> no q change, busy_311 never high, done_311 pulse on the cycle after accept.
  - start_311 asserted during RUN of a steps = 5 count -> ignored; exactly 5 increments occur.
- Reset mid-operation: COUNT_UP with steps = 10, reset asserted at the 4th RUN edge -> q_311 = 0000, FSM IDLE, done_311 never pulses; a fresh SET command afterwards gives q = 1111.
